// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and sequencer state encoding
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  typedef logic [1:0] seqState;
  localparam seqState IDLE    = 2'd0;
  localparam seqState DRIVE   = 2'd1;
  localparam seqState CAPTURE = 2'd2;
  localparam seqState RESP    = 2'd3;
  function automatic logic isError(input logic [1:0] op, input logic bZero);
    return op == OP_RSV || (op == OP_DIV && bZero);
  endfunction
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: hands one request at a time to an external ALU and returns its registered result
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH:0]   req_a,
  input  logic [WIDTH:0]   req_b,
  input  logic [1:0]       req_op,
  input  logic             req_ci,
  output logic [WIDTH:0]   alu_a,
  output logic [WIDTH:0]   alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_ci,
  input  logic [WIDTH:0]   alu_out,
  input  logic             alu_co,
  input  logic             alu_negativo,
  input  logic             alu_cero,
  input  logic             alu_acarreo,
  input  logic             alu_desbordamiento,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_error,
  output logic [3:0]       flags_q
);
  seqState state;
  logic [2:0] settleCnt;
  logic accept;
  logic [3:0] aluFlags;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  assign aluFlags = {alu_negativo, alu_cero, alu_acarreo | alu_co, alu_desbordamiento};
  // sequencing FSM: accept, hold operands SETTLE cycles, capture, then hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settleCnt  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
      alu_ci     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_error  <= 1'b0;
      flags_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (isError(req_op, req_b == '0)) begin
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_error  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a     <= req_a;
              alu_b     <= req_b;
              alu_op    <= req_op;
              alu_ci    <= req_ci;
              settleCnt <= '0;
              state     <= DRIVE;
            end
          end
        end
        DRIVE: begin
          settleCnt <= settleCnt == 3'(SETTLE - 1) ? '0 : settleCnt + 1'b1;
          state     <= settleCnt == 3'(SETTLE - 1) ? CAPTURE : DRIVE;
        end
        CAPTURE: begin
          rsp_result <= alu_out;
          rsp_flags  <= aluFlags;
          flags_q    <= aluFlags;
          rsp_error  <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
      endcase
    end
  end
endmodule
